// File: rtl/phase_timer_pkg.sv
// Shared types and constants for the multi-phase cycle-count sequencer.
package phase_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] MARK_ADDR_DEF = 32'h1000_0000;
    localparam logic [31:0] SENTINEL_DEF  = 32'h7fff_ffff;
    localparam int          PHASE_W       = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag for an increment that hit the ceiling.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // clr has priority over en so a start on a counting cycle still clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en) begin
            if (count == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_timer_seq.sv
// Bus-snooping phase sequencer: marker writes advance phases, one saturating
// cycle counter per phase, registered readback of the counts.
module phase_timer_seq
    import phase_timer_pkg::*;
#(
    parameter int          NUM_PHASES = 4,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] MARK_ADDR  = MARK_ADDR_DEF,
    parameter logic [31:0] SENTINEL   = SENTINEL_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  bus_valid,
    input  logic                  bus_we,
    input  logic [31:0]           bus_addr,
    input  logic [31:0]           bus_wdata,
    input  logic                  rd_en,
    input  logic [PHASE_W-1:0]    rd_idx,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] ovf
);

    state_t               state_reg, state_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;
    logic                 marker;
    logic [CNT_W-1:0]     cnt [NUM_PHASES];
    logic [CNT_W-1:0]     rd_mux;

    assign marker = bus_valid && bus_we && (bus_addr == MARK_ADDR) && (bus_wdata == SENTINEL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            phase_reg <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
        end
    end

    // start overrides everything, including a marker in the same cycle.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        if (start) begin
            state_next = RUN;
            phase_next = '0;
        end else if (state_reg == RUN && marker) begin
            if (phase_reg == PHASE_W'(NUM_PHASES - 1)) begin
                state_next = DONE;
            end else begin
                phase_next = phase_reg + 1'b1;
            end
        end
    end

    always_comb begin
        busy  = (state_reg == RUN);
        done  = (state_reg == DONE);
        phase = phase_reg;
    end

    // The marker edge itself still counts: en looks at the current phase.
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .resetn (resetn),
            .clr    (start),
            .en     (busy && (phase_reg == PHASE_W'(gi))),
            .count  (cnt[gi]),
            .sat    (ovf[gi])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (rd_idx == PHASE_W'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_phase_timer_seq.sv
// Directed and randomized checks of phase_timer_seq (32-bit and 4-bit counters)
// against an unbounded-count reference model.
module tb_phase_timer_seq;

    localparam logic [31:0] MA = 32'h1000_0000;
    localparam logic [31:0] SN = 32'h7fff_ffff;
    localparam int          NP = 4;
    localparam longint      MAX_A = 64'h0000_0000_ffff_ffff;
    localparam longint      MAX_B = 15;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_idx = '0;

    logic [31:0] rd_data_a;
    logic        rd_valid_a, busy_a, done_a;
    logic [3:0]  phase_a;
    logic [3:0]  ovf_a;
    logic [3:0]  rd_data_b;
    logic        rd_valid_b, busy_b, done_b;
    logic [3:0]  phase_b;
    logic [3:0]  ovf_b;

    phase_timer_seq #(.NUM_PHASES(NP), .CNT_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .busy(busy_a), .done(done_a),
        .phase(phase_a), .ovf(ovf_a)
    );

    phase_timer_seq #(.NUM_PHASES(NP), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .start(start), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b), .done(done_b),
        .phase(phase_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    // Reference model: mode 0=idle 1=running 2=finished; counts are unbounded,
    // saturation is applied only when forming the expected outputs.
    int     m_mode;
    int     m_phase;
    longint m_cnt [NP];
    longint exp_rd_a, exp_rd_b;
    bit     exp_rv;

    function automatic longint cap(input longint c, input longint mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic [3:0] exp_ovf(input longint mx);
        logic [3:0] r;
        for (int i = 0; i < NP; i++) r[i] = (m_cnt[i] > mx);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; exp_rd_a = 0; exp_rd_b = 0; exp_rv = 0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".busy"},  busy_a, (m_mode == 1));
        check({tag, ".done"},  done_a, (m_mode == 2));
        check({tag, ".phase"}, phase_a, m_phase);
        check({tag, ".rdv"},   rd_valid_a, exp_rv);
        check({tag, ".ovf_a"}, ovf_a, exp_ovf(MAX_A));
        check({tag, ".ovf_b"}, ovf_b, exp_ovf(MAX_B));
        check({tag, ".rd_a"},  rd_data_a, exp_rd_a);
        check({tag, ".rd_b"},  rd_data_b, exp_rd_b);
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check 1 time unit later.
    task automatic step(input bit st, input bit v, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input bit re, input logic [3:0] idx);
        bit mk;
        @(negedge clk);
        start = st; bus_valid = v; bus_we = we; bus_addr = addr; bus_wdata = data;
        rd_en = re; rd_idx = idx;
        @(posedge clk);
        mk = v && we && (addr == MA) && (data == SN);
        exp_rv = re;
        if (re) begin
            exp_rd_a = (idx < NP) ? cap(m_cnt[idx], MAX_A) : 0;
            exp_rd_b = (idx < NP) ? cap(m_cnt[idx], MAX_B) : 0;
        end
        if (st) begin
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
            m_mode = 1; m_phase = 0;
        end else if (m_mode == 1) begin
            m_cnt[m_phase]++;
            if (mk) begin
                if (m_phase == NP - 1) m_mode = 2;
                else m_phase++;
            end
        end
        #1;
        check_all("cyc");
        if (re) $display("read idx=%0d data_a=%0d data_b=%0d", idx, rd_data_a, rd_data_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, 0, 4'd0);
    endtask

    task automatic do_start();
        step(1, 0, 0, 32'h0, 32'h0, 0, 4'd0);
    endtask

    task automatic mark();
        step(0, 1, 1, MA, SN, 0, 4'd0);
    endtask

    task automatic phase_len(input int n);
        idle(n - 1);
        mark();
    endtask

    task automatic read(input logic [3:0] idx);
        step(0, 0, 0, 32'h0, 32'h0, 1, idx);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Basic run: phases of 10, 20, 5, 7 cycles.
        do_start();
        phase_len(10); phase_len(20); phase_len(5); phase_len(7);
        check("basic.cnt0", m_cnt[0], 10);
        check("basic.done", done_a, 1'b1);
        for (int i = 0; i < NP; i++) read(4'(i));
        read(4'd9);
        check("basic.idx9", rd_data_a, 32'd0);
        mark();
        for (int i = 0; i < NP; i++) read(4'(i));

        // Near-miss writes in phase 0, then same-cycle start and marker in phase 2.
        do_start();
        idle(3);
        step(0, 1, 1, MA, 32'h7fff_fffe, 0, 4'd0);
        step(0, 1, 1, MA + 32'd4, SN, 0, 4'd0);
        step(0, 1, 0, MA, SN, 0, 4'd0);
        phase_len(4); phase_len(3); idle(2);
        step(1, 1, 1, MA, SN, 0, 4'd0);
        check("startwin.phase", phase_a, 4'd0);
        read(4'd1);

        // 20-cycle phase saturates the 4-bit counter.
        do_start();
        phase_len(20);
        read(4'd0);
        check("sat.ovf_b", ovf_b, 4'b0001);
        idle(3);

        // Asynchronous reset in the middle of phase 1.
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        @(negedge clk);
        resetn = 1'b1;
        mark();
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bit st, v, we, re;
            logic [31:0] addr, data;
            st   = ($urandom_range(0, 59) == 0);
            v    = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 3) == 0) ? MA + 32'd4 : MA;
            data = ($urandom_range(0, 9) == 0) ? SN : $urandom;
            re   = $urandom_range(0, 1) == 1;
            step(st, v, we, addr, data, re, 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
